// File: rtl/sdiv_ctrl_pkg.sv
// Shared definitions for the signed/unsigned divide controller.
package sdiv_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StFix,
    StResp
  } sdiv_state_e;

  // Sized for the widest supported datapath and sliced down to WIDTH at use.
  localparam int unsigned MaxWidth = 64;
  localparam logic [MaxWidth-1:0] DivZeroQuotient = '1;

endpackage

// File: rtl/sdiv_ctrl_if.sv
// Request, divider and response signals of the divide controller.
// slave is the controller's view, master is the requester/divider side.
interface sdiv_ctrl_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             req_valid;
  logic             req_ready;
  logic             req_signed;
  logic [WIDTH-1:0] req_dividend;
  logic [WIDTH-1:0] req_divisor;

  logic             div_start;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;
  logic             div_done;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_quotient;
  logic [WIDTH-1:0] rsp_remainder;
  logic             rsp_div_zero;

  modport master (
    output req_valid, req_signed, req_dividend, req_divisor,
    input  req_ready,
    input  div_start, div_dividend, div_divisor,
    output div_quotient, div_remainder, div_done,
    input  rsp_valid, rsp_quotient, rsp_remainder, rsp_div_zero,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_signed, req_dividend, req_divisor,
    output req_ready,
    output div_start, div_dividend, div_divisor,
    input  div_quotient, div_remainder, div_done,
    output rsp_valid, rsp_quotient, rsp_remainder, rsp_div_zero,
    input  rsp_ready
  );

endinterface

// File: rtl/sdiv_ctrl_twos_negate.sv
// Combinational two's-complement negation; wraps, so MIN maps to MIN.
module sdiv_ctrl_twos_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = (~a) + WIDTH'(1);

endmodule

// File: rtl/sdiv_ctrl.sv
// Wraps an external unsigned iterative divider to provide signed and unsigned
// division with divide-by-zero handling. One transaction outstanding at a time.
module sdiv_ctrl #(
  parameter int unsigned WIDTH = 32  // at most sdiv_ctrl_pkg::MaxWidth
) (
  input logic        clk,
  input logic        rst,
  sdiv_ctrl_if.slave bus
);

  import sdiv_ctrl_pkg::*;

  sdiv_state_e      state_q;
  logic             req_ready_q;
  logic             div_start_q;
  logic             rsp_valid_q;
  logic             rsp_div_zero_q;
  logic [WIDTH-1:0] div_dividend_q;
  logic [WIDTH-1:0] div_divisor_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] rsp_quotient_q;
  logic [WIDTH-1:0] rsp_remainder_q;
  logic             neg_quot_q;
  logic             neg_rem_q;

  logic [WIDTH-1:0] dividend_neg;
  logic [WIDTH-1:0] divisor_neg;
  logic [WIDTH-1:0] quot_neg;
  logic [WIDTH-1:0] rem_neg;
  logic             dividend_is_neg;
  logic             divisor_is_neg;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;

  sdiv_ctrl_twos_negate #(.WIDTH(WIDTH)) u_neg_dividend (.a(bus.req_dividend), .y(dividend_neg));
  sdiv_ctrl_twos_negate #(.WIDTH(WIDTH)) u_neg_divisor  (.a(bus.req_divisor),  .y(divisor_neg));
  sdiv_ctrl_twos_negate #(.WIDTH(WIDTH)) u_neg_quot     (.a(quot_q),           .y(quot_neg));
  sdiv_ctrl_twos_negate #(.WIDTH(WIDTH)) u_neg_rem      (.a(rem_q),            .y(rem_neg));

  // Operand magnitudes; a signed MIN stays MIN and is treated as unsigned.
  always_comb begin
    dividend_is_neg = bus.req_signed & bus.req_dividend[WIDTH-1];
    divisor_is_neg  = bus.req_signed & bus.req_divisor[WIDTH-1];
    dividend_mag    = dividend_is_neg ? dividend_neg : bus.req_dividend;
    divisor_mag     = divisor_is_neg  ? divisor_neg  : bus.req_divisor;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      req_ready_q     <= 1'b1;
      div_start_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_div_zero_q  <= 1'b0;
      div_dividend_q  <= '0;
      div_divisor_q   <= '0;
      quot_q          <= '0;
      rem_q           <= '0;
      rsp_quotient_q  <= '0;
      rsp_remainder_q <= '0;
      neg_quot_q      <= 1'b0;
      neg_rem_q       <= 1'b0;
    end else begin
      div_start_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            req_ready_q <= 1'b0;
            neg_quot_q  <= dividend_is_neg ^ divisor_is_neg;
            neg_rem_q   <= dividend_is_neg;
            if (bus.req_divisor == '0) begin
              rsp_quotient_q  <= DivZeroQuotient[WIDTH-1:0];
              rsp_remainder_q <= bus.req_dividend;
              rsp_div_zero_q  <= 1'b1;
              rsp_valid_q     <= 1'b1;
              state_q         <= StResp;
            end else begin
              div_dividend_q <= dividend_mag;
              div_divisor_q  <= divisor_mag;
              div_start_q    <= 1'b1;
              state_q        <= StIssue;
            end
          end
        end
        StIssue: state_q <= StWait;
        StWait: begin
          if (bus.div_done) begin
            quot_q  <= bus.div_quotient;
            rem_q   <= bus.div_remainder;
            state_q <= StFix;
          end
        end
        StFix: begin
          rsp_quotient_q  <= neg_quot_q ? quot_neg : quot_q;
          rsp_remainder_q <= neg_rem_q  ? rem_neg  : rem_q;
          rsp_div_zero_q  <= 1'b0;
          rsp_valid_q     <= 1'b1;
          state_q         <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.div_start     = div_start_q;
  assign bus.div_dividend  = div_dividend_q;
  assign bus.div_divisor   = div_divisor_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_quotient  = rsp_quotient_q;
  assign bus.rsp_remainder = rsp_remainder_q;
  assign bus.rsp_div_zero  = rsp_div_zero_q;

endmodule

// File: tb/tb_sdiv_ctrl.sv
// Directed bench for sdiv_ctrl with a variable-latency divider model.
module tb_sdiv_ctrl;
  import sdiv_ctrl_pkg::*;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  // Divider model state
  int          div_lat;
  int          cnt;
  logic        mdl_done;
  logic        inj_done;
  logic [31:0] mdl_q;
  logic [31:0] mdl_r;

  sdiv_ctrl_if #(.WIDTH(32)) bus ();

  sdiv_ctrl #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Results only valid in the done cycle; garbage otherwise.
  assign bus.div_done      = mdl_done | inj_done;
  assign bus.div_quotient  = mdl_done ? mdl_q : 32'hDEAD_BEEF;
  assign bus.div_remainder = mdl_done ? mdl_r : 32'hBAD0_CAFE;

  // Done lands div_lat cycles after the div_start cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_done <= 1'b0;
      cnt      <= 0;
      mdl_q    <= '0;
      mdl_r    <= '0;
    end else begin
      mdl_done <= 1'b0;
      if (bus.div_start) begin
        mdl_q <= (bus.div_divisor != 0) ? bus.div_dividend / bus.div_divisor : '1;
        mdl_r <= (bus.div_divisor != 0) ? bus.div_dividend % bus.div_divisor : bus.div_dividend;
        if (div_lat <= 1) mdl_done <= 1'b1;
        else cnt <= div_lat - 1;
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) mdl_done <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    div_lat          = v.lat;
    bus.req_signed   = v.sgn;
    bus.req_dividend = v.a;
    bus.req_divisor  = v.b;
    bus.req_valid    = 1'b1;
  endtask

  // Called just after the accept edge: checks latency, start pulses, results, then handshakes.
  task automatic finish_vec(input vec_t v);
    int k;
    int starts;
    k = 0;
    starts = 0;
    do begin
      @(negedge clk);
      k++;
      if (bus.div_start) starts++;
    end while (!bus.rsp_valid && k < 200);
    check("latency", 32'(k), v.dz ? 32'd1 : 32'(v.lat + 3));
    check("start_pulses", 32'(starts), v.dz ? 32'd0 : 32'd1);
    check("quotient", bus.rsp_quotient, v.q);
    check("remainder", bus.rsp_remainder, v.r);
    check("div_zero", 32'(bus.rsp_div_zero), 32'(v.dz));
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive_req(v);
    check("req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    finish_vec(v);
  endtask

  vec_t        vecs[10];
  vec_t        vb1;
  vec_t        vb2;
  vec_t        vr;
  logic [31:0] snap_q;
  logic [31:0] snap_r;
  int          k;
  int          seen;

  initial begin
    vecs[0] = '{1'b0, 32'd100,        32'd7,          3, 32'd14,         32'd2,         1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          1, 32'hFFFF_FFFD,  32'hFFFF_FFFF, 1'b0};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  5, 32'hFFFF_FFFD,  32'd1,         1'b0};
    vecs[3] = '{1'b0, 32'h0000_1234,  32'd0,          3, 32'hFFFF_FFFF,  32'h0000_1234, 1'b1};
    vecs[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  2, 32'h8000_0000,  32'd0,         1'b0};
    vecs[5] = '{1'b0, 32'hFFFF_FFF9,  32'd2,          4, 32'h7FFF_FFFC,  32'd1,         1'b0};
    vecs[6] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  2, 32'd14,         32'hFFFF_FFFE, 1'b0};
    vecs[7] = '{1'b1, 32'd0,          32'd0,          2, 32'hFFFF_FFFF,  32'd0,         1'b1};
    vecs[8] = '{1'b1, 32'h8000_0000,  32'd2,          1, 32'hC000_0000,  32'd0,         1'b0};
    vecs[9] = '{1'b0, 32'h8000_0000,  32'h8000_0000,  6, 32'd1,          32'd0,         1'b0};
    vb1     = '{1'b0, 32'd50,         32'd5,          2, 32'd10,         32'd0,         1'b0};
    vb2     = '{1'b1, 32'hFFFF_FFF7,  32'd4,          3, 32'hFFFF_FFFE,  32'hFFFF_FFFF, 1'b0};
    vr      = '{1'b0, 32'd1000,       32'd10,        20, 32'd100,        32'd0,         1'b0};

    n_cmp = 0;
    n_err = 0;
    div_lat = 1;
    inj_done = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_signed = 1'b0;
    bus.req_dividend = '0;
    bus.req_divisor = '0;
    bus.rsp_ready = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_div_start", 32'(bus.div_start), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_div_zero", 32'(bus.rsp_div_zero), 32'd0);
    check("rst_quotient", bus.rsp_quotient, 32'd0);
    check("rst_div_dividend", bus.div_dividend, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Backpressure with a second request waiting behind the response.
    @(negedge clk);
    drive_req(vb1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.rsp_valid && k < 200);
    check("bp_quotient", bus.rsp_quotient, vb1.q);
    snap_q = bus.rsp_quotient;
    snap_r = bus.rsp_remainder;
    drive_req(vb2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_hold_q", bus.rsp_quotient, snap_q);
      check("bp_hold_r", bus.rsp_remainder, snap_r);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("b2b_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    finish_vec(vb2);

    // Reset during WAIT, then a stray div_done.
    @(negedge clk);
    drive_req(vr);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("pre_rst_in_wait", 32'(dut.state_q), 32'(StWait));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_state", 32'(dut.state_q), 32'(StIdle));
    check("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("mid_rst_div_dividend", bus.div_dividend, 32'd0);
    check("mid_rst_quotient", bus.rsp_quotient, 32'd0);
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("late_done_rsp_valid", 32'(seen), 32'd0);
    check("late_done_state", 32'(dut.state_q), 32'(StIdle));

    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/sdiv_ctrl.md
SDIV_CTRL -- requirements
Module: sdiv_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  CPU division request present.
REQ-006 req_ready  out  1  request accepted when high together with req_valid.
REQ-007 req_signed  in  1  1 = two's-complement operands, 0 = unsigned.
REQ-008 req_dividend, req_divisor  in  WIDTH each  operands.
REQ-009 div_start  out  1  one-cycle start pulse to the unsigned iterative divider.
REQ-010 div_dividend, div_divisor  out  WIDTH each  operand magnitudes to the divider.
REQ-011 div_quotient, div_remainder  in  WIDTH each  unsigned divider results.
REQ-012 div_done  in  1  divider completion pulse; results are valid in the same cycle.
REQ-013 rsp_valid  out  1  result available.
REQ-014 rsp_ready  in  1  consumer accepts the result.
REQ-015 rsp_quotient, rsp_remainder  out  WIDTH each  final signed or unsigned result.
REQ-016 rsp_div_zero  out  1  divisor was zero.

Function
REQ-017 SHALL implement the FSM IDLE, ISSUE, WAIT, FIX, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE, which makes the block single-outstanding.
REQ-019 IDLE, on a req handshake, SHALL register the operands and the signed flag, then branch:
- divisor==0: go to RESP with quotient = all ones, remainder = dividend, div_zero = 1.
- otherwise: go to ISSUE.
REQ-020 Operand magnitudes SHALL be formed as follows:
- signed and MSB set: two's-complement negation.
- otherwise: the operand unchanged.
- 0x80..0 therefore maps to 0x80..0, read as unsigned.
REQ-021 ISSUE SHALL assert div_start for exactly one cycle, then go to WAIT.
REQ-022 div_dividend and div_divisor SHALL hold the magnitudes stable from ISSUE through the div_done cycle.
REQ-023 WAIT SHALL capture div_quotient and div_remainder on the div_done cycle, then go to FIX.
REQ-024 The block SHALL NOT assume any fixed divider latency.
REQ-025 div_done seen outside WAIT SHALL be ignored.
REQ-026 FIX SHALL apply sign correction in one cycle, then go to RESP:
- quotient negated iff signed and the operand signs differ.
- remainder negated iff signed and the dividend is negative.
REQ-027 Signed MIN / -1 SHALL give quotient = MIN and remainder = 0, with no special-case logic.
REQ-028 RESP SHALL hold rsp_valid and all rsp_* outputs stable until rsp_ready, then return to IDLE.
REQ-029 After the rsp handshake, req_ready SHALL be 1 in the next cycle, so back-to-back requests are possible.
REQ-030 Latency: with L = cycles from the div_start cycle to the div_done cycle, rsp_valid SHALL rise L+3 cycles after the accept cycle.
REQ-031 Divide-by-zero SHALL raise rsp_valid in the cycle after accept, and div_start SHALL never assert.
REQ-032 rsp_div_zero SHALL be 0 for all non-zero divisors.
REQ-033 All arithmetic SHALL be WIDTH bits with wrap-around; no overflow flag.

Reset
REQ-034 While rst=1, SHALL force the following immediately and asynchronously:
- state = IDLE.
- req_ready = 1.
- div_start = 0, rsp_valid = 0, rsp_div_zero = 0.
- all data outputs = 0.
REQ-035 Reset asserted mid-operation SHALL abandon the transaction; a late div_done after reset SHALL have no effect.

Structure
REQ-036 The state enum and the divide-by-zero quotient constant SHALL live in the shared cpu package.
REQ-037 A sub-module is natural for negation/abs: twos_negate, combinational, parameterized by WIDTH, instantiated for magnitudes and for sign fix.
REQ-038 The unsigned divider SHALL be instantiated by the parent alongside sdiv_ctrl, not inside it.

Verification (WIDTH=32, real divider connected)
REQ-039 Unsigned 100 / 7 -> q=14, r=2, div_zero=0, rsp_valid L+3 cycles after accept.
REQ-040 Signed 0xFFFFFFF9 (-7) / 2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; and 7 / 0xFFFFFFFE -> q=0xFFFFFFFD, r=1.
REQ-041 Divisor 0, dividend 0x1234 -> q=0xFFFFFFFF, r=0x1234, div_zero=1, rsp_valid next cycle, div_start never high.
REQ-042 Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0.
REQ-043 Backpressure case:
- stimulus: rsp_ready held low 5 cycles during RESP.
- required: outputs stable and req_ready=0 throughout.
- required: a second request waiting on req_valid is accepted the cycle after the rsp handshake.
REQ-044 Reset mid-operation case:
- stimulus: rst pulsed during WAIT, then div_done injected.
- required: outputs reset asynchronously and the FSM is in IDLE.
- required: the injected div_done produces no rsp_valid.
